// File: rtl/action_selector.sv
// rtl/action_selector.sv - epsilon-greedy action selector over a 4-field Q word
module action_selector #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  state,
  input  logic [7:0]  epsilon,
  output logic [5:0]  rd_addr,
  input  logic [15:0] ram_data,
  output logic [1:0]  action,
  output logic [3:0]  q_val,
  output logic        explored,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, FETCH, COMPARE, DECIDE, DONE} fsm_t;

  fsm_t        fsm;
  logic [7:0]  eps_q;
  logic [15:0] word_q;
  logic [1:0]  best_idx;
  logic [3:0]  best_val;
  logic [1:0]  idx;
  logic [15:0] lfsr;

  function automatic logic [3:0] field(input logic [15:0] w, input logic [1:0] a);
    return w[{a, 2'b00} +: 4];
  endfunction

  assign busy = (fsm != IDLE);

  // Free-running Galois LFSR, shifts right every cycle out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      eps_q    <= 8'd0;
      word_q   <= 16'd0;
      best_idx <= 2'd0;
      best_val <= 4'd0;
      idx      <= 2'd0;
      rd_addr  <= 6'd0;
      action   <= 2'd0;
      q_val    <= 4'd0;
      explored <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            eps_q   <= epsilon;
            rd_addr <= state;
            fsm     <= FETCH;
          end
        end
        FETCH: begin
          word_q   <= ram_data;
          best_idx <= 2'd0;
          best_val <= 4'd0;
          idx      <= 2'd0;
          fsm      <= COMPARE;
        end
        COMPARE: begin
          // Strict compare keeps the lowest index on ties
          if (field(word_q, idx) > best_val) begin
            best_val <= field(word_q, idx);
            best_idx <= idx;
          end
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            fsm <= DECIDE;
          end
        end
        DECIDE: begin
          if (lfsr[7:0] < eps_q) begin
            action   <= lfsr[9:8];
            q_val    <= field(word_q, lfsr[9:8]);
            explored <= 1'b1;
          end else begin
            action   <= best_idx;
            q_val    <= field(word_q, best_idx);
            explored <= 1'b0;
          end
          done <= 1'b1;
          fsm  <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          fsm  <= IDLE;
        end
        default: begin
          done <= 1'b0;
          fsm  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_action_selector.sv
// tb/tb_action_selector.sv - directed self-checking bench for action_selector
module tb_action_selector;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  state = 6'd0;
  logic [7:0]  epsilon = 8'd0;
  logic [5:0]  rd_addr;
  logic [15:0] ram_data;
  logic [1:0]  action;
  logic [3:0]  q_val;
  logic        explored;
  logic        done;
  logic        busy;

  logic [15:0] ram [64];
  logic        corrupt = 1'b0;
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  int vec_cnt = 0;
  int err_cnt = 0;

  action_selector #(.LFSR_SEED(SEED)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .state    (state),
    .epsilon  (epsilon),
    .rd_addr  (rd_addr),
    .ram_data (ram_data),
    .action   (action),
    .q_val    (q_val),
    .explored (explored),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign ram_data = corrupt ? ~ram[rd_addr] : ram[rd_addr];

  // Reference LFSR; m_prev holds the value that was current before the last edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= SEED;
      m_prev <= 16'd0;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_sel(input logic [5:0] st, input logic [7:0] eps, input bit mangle,
                         input string tag);
    int          cyc;
    logic [15:0] w;
    logic [1:0]  best;
    logic [3:0]  bv;
    logic [1:0]  ea;
    logic        ex;
    @(negedge clk);
    state   = st;
    epsilon = eps;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    chk({tag, "_rd_addr"}, 16'(rd_addr), 16'(st));
    while (!done && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (mangle && cyc == 2) corrupt = 1'b1;
    end
    corrupt = 1'b0;
    chk({tag, "_latency"}, 16'(cyc), 16'd7);
    w    = ram[st];
    best = 2'd0;
    bv   = w[3:0];
    for (int i = 1; i < 4; i++) begin
      if (w[4*i +: 4] > bv) begin
        bv   = w[4*i +: 4];
        best = 2'(i);
      end
    end
    ex = (m_prev[7:0] < eps);
    ea = ex ? m_prev[9:8] : best;
    chk({tag, "_action"}, 16'(action), 16'(ea));
    chk({tag, "_q_val"}, 16'(q_val), 16'(w[{ea, 2'b00} +: 4]));
    chk({tag, "_explored"}, 16'(explored), 16'(ex));
    chk({tag, "_busy"}, 16'(busy), 16'd1);
  endtask

  initial begin
    int dcnt;
    int first;
    int last;
    bit space_ok;
    for (int i = 0; i < 64; i++) ram[i] = 16'(i * 16'h9E37) ^ 16'h5A5A;
    ram[5] = 16'h3A52;
    ram[9] = 16'h7777;
    ram[12] = 16'h1F0C;

    #12;
    chk("reset_rd_addr", 16'(rd_addr), 16'd0);
    chk("reset_action", 16'(action), 16'd0);
    chk("reset_q_val", 16'(q_val), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sel(6'd5, 8'd0, 1'b0, "greedy");
    chk("greedy_hand_action", 16'(action), 16'd2);
    chk("greedy_hand_q", 16'(q_val), 16'hA);
    run_sel(6'd9, 8'd0, 1'b0, "tie");
    chk("tie_hand_action", 16'(action), 16'd0);
    chk("tie_hand_q", 16'(q_val), 16'd7);
    run_sel(6'd12, 8'd0, 1'b1, "isolate");
    chk("isolate_hand_q", 16'(q_val), 16'hF);

    for (int k = 0; k < 6; k++) run_sel(6'(k * 7 + 3), 8'd255, 1'b0, "explore");
    run_sel(6'd20, 8'd128, 1'b0, "eps_mid");
    run_sel(6'd33, 8'd1, 1'b0, "eps_one");

    // Start held for 20 edges: expect done at negedges 7, 15, 23
    @(negedge clk);
    state   = 6'd5;
    epsilon = 8'd0;
    start   = 1'b1;
    dcnt = 0; first = 0; last = 0; space_ok = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 20) start = 1'b0;
      if (done) begin
        if (dcnt == 0) first = i;
        else if (i - last != 8) space_ok = 1'b0;
        last = i;
        dcnt++;
      end
    end
    chk("busy_done_count", 16'(dcnt), 16'd3);
    chk("busy_first_done", 16'(first), 16'd7);
    chk("busy_spacing", 16'(space_ok), 16'd1);

    run_sel(6'd5, 8'd0, 1'b0, "pre_reset");
    @(negedge clk);
    state = 6'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_addr", 16'(rd_addr), 16'd0);
    chk("midrst_action", 16'(action), 16'd0);
    chk("midrst_q_val", 16'(q_val), 16'd0);
    chk("midrst_explored", 16'(explored), 16'd0);
    chk("midrst_done", 16'(done), 16'd0);
    chk("midrst_busy", 16'(busy), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midrst_no_done", 16'(dcnt), 16'd0);
    run_sel(6'd5, 8'd255, 1'b0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/action_selector.md
ACTION_SELECTOR -- requirements
Module: action_selector

Interface
- REQ-001: Parameter LFSR_SEED, default 16'hACE1, is the LFSR reset value; it shall be nonzero.
- REQ-002: clk  input  1  single clock; all state changes occur on its rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous and active-low.
- REQ-004: start  input  1  request one action selection for `state`; sampled only in IDLE.
- REQ-005: state  input  6  current maze state index, latched when start is accepted.
- REQ-006: epsilon  input  8  exploration threshold, latched when start is accepted.
- REQ-007: rd_addr  output  6  read address driven to the action RAM.
- REQ-008: ram_data  input  16  action RAM read data, combinational from rd_addr.
- REQ-009: action  output  2  selected action, 0..3.
- REQ-010: q_val  output  4  Q field of the selected action.
- REQ-011: explored  output  1  1 = the action was chosen randomly; 0 = greedy.
- REQ-012: done  output  1  one-cycle pulse when action, q_val and explored are valid.
- REQ-013: busy  output  1  high in every state except IDLE.

Function
- REQ-014: The RAM word shall hold four unsigned 4-bit Q fields; the field for action a is at bits [4a+3:4a].
- REQ-015: The FSM shall have exactly the states IDLE, FETCH, COMPARE, DECIDE and DONE.
- REQ-016: IDLE with start=1 shall latch state and epsilon, drive rd_addr=state, and go to FETCH; IDLE with start=0 shall stay in IDLE.
- REQ-017: FETCH shall register ram_data into an internal word register, clear the best index and best value to 0, and go to COMPARE.
- REQ-018: COMPARE shall take exactly 4 cycles, examining index i=0..3 (one per cycle).
  - Replace best with field i when field i > best, strict compare.
  - Ties therefore keep the lowest index.
  - After i=3, go to DECIDE.
- REQ-019: DECIDE shall choose between explore and greedy, update the outputs, and go to DONE:
  - If lfsr[7:0] < latched epsilon: action=lfsr[9:8], explored=1.
  - Otherwise: action=best index, explored=0.
  - In both cases q_val = word field of the chosen action.
- REQ-020: DONE shall assert done for exactly one cycle and return to IDLE.
- REQ-021: Latency from the accepting start edge (cycle 0) shall be done high in cycle 7 (FETCH 1, COMPARE 2-5, DECIDE 6, DONE 7); back-to-back selections shall repeat every 8 cycles.
- REQ-022: start while busy=1 shall be ignored, with no queuing; start asserted during DONE shall not be accepted until IDLE.
- REQ-023: rd_addr shall hold the latched state from acceptance until the next acceptance.
- REQ-024: action, q_val and explored shall hold their values between DECIDE updates.
- REQ-025: The LFSR shall be a 16-bit Galois LFSR, polynomial mask 16'hB400, shifting right every cycle while rst_n=1, free-running regardless of FSM state.
- REQ-026: epsilon=0 shall never explore.
- REQ-027: epsilon=255 shall explore unless lfsr[7:0]==8'hFF.
- REQ-028: ram_data changes outside FETCH shall have no effect on the result.

Reset
- REQ-029: rst_n=0 shall immediately return the FSM to IDLE and drive the following, at any time including mid-selection:
  - rd_addr=0, action=0, q_val=0, explored=0, done=0, busy=0.
  - Word register and best registers=0.
  - lfsr=LFSR_SEED.
- REQ-030: The first start shall be accepted on the first rising edge with rst_n=1 and start=1.

Verification
- REQ-031: Greedy pick: state=5, RAM[5]=16'h3A52, epsilon=0, start pulse -> rd_addr=5; done in cycle 7; action=2, q_val=4'hA, explored=0.
- REQ-032: Tie-break: RAM[9]=16'h7777, epsilon=0 -> action=0, q_val=7.
- REQ-033: Explore: epsilon=255, bench LFSR model -> whenever the model's lfsr[7:0]!=FF in DECIDE: explored=1, action=model lfsr[9:8], q_val=matching field.
- REQ-034: Busy rejection: start held high for 20 cycles -> exactly 3 done pulses, spaced 8 cycles apart.
- REQ-035: Reset mid-op: rst_n low in COMPARE cycle 3 -> all outputs 0 that cycle; no done; the next start behaves as from power-up.
- REQ-036: Data isolation: change ram_data during COMPARE -> result matches the word captured in FETCH.
